// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the write-back arbiter and its round-robin helper.
package wb_arbiter_pkg;

  localparam int WB_DATA_W = 64;
  localparam int WB_ADDR_W = 5;
  localparam int NUM_SRC   = 3;

  localparam logic [63:0] ZERO64 = 64'h0;

  // Source indices double as bit positions in request/grant vectors.
  typedef enum logic [1:0] {
    SRC_LSU = 2'd0,
    SRC_MDU = 2'd1,
    SRC_ALU = 2'd2
  } src_e;

  // Successor in the circular order LSU -> MDU -> ALU -> LSU.
  function automatic logic [1:0] next_src(input logic [1:0] s);
    return (s >= 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_arb3.sv
// Three-way combinational round-robin arbiter: one-hot grant plus the
// pointer value to use after that grant.
module rr_arb3
  import wb_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt,
  output logic [1:0] next_ptr
);

  logic [1:0] idx;
  logic       found;

  // Walk the sources starting at the pointer; the first requester wins and
  // the pointer moves to the source after it. No request keeps the pointer.
  always_comb begin
    gnt      = 3'b000;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = (ptr > 2'd2) ? 2'd0 : ptr;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        next_ptr = next_src(idx);
        found    = 1'b1;
      end
      idx = next_src(idx);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back scheduler: buffers ALU/LSU/MDU results in one slot each and
// drives a single registered regfile write per cycle, round-robin.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [ADDR_W-1:0] mdu_rd,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              wb_busy
);

  logic [2:0]        occ;
  logic [2:0]        in_valid;
  logic [2:0]        ready;
  logic [2:0]        gnt;
  logic [1:0]        ptr;
  logic [1:0]        next_ptr;
  logic [ADDR_W-1:0] slot_rd   [NUM_SRC];
  logic [DATA_W-1:0] slot_data [NUM_SRC];
  logic [ADDR_W-1:0] in_rd     [NUM_SRC];
  logic [DATA_W-1:0] in_data   [NUM_SRC];
  logic [ADDR_W-1:0] win_rd;
  logic [DATA_W-1:0] win_data;

  assign in_valid[SRC_LSU] = lsu_valid;
  assign in_valid[SRC_MDU] = mdu_valid;
  assign in_valid[SRC_ALU] = alu_valid;
  assign in_rd[SRC_LSU]    = lsu_rd;
  assign in_rd[SRC_MDU]    = mdu_rd;
  assign in_rd[SRC_ALU]    = alu_rd;
  assign in_data[SRC_LSU]  = lsu_data;
  assign in_data[SRC_MDU]  = mdu_data;
  assign in_data[SRC_ALU]  = alu_data;

  // A slot accepts when empty or when it is being drained this cycle, so a
  // streaming source sees no bubble. Nothing is accepted while in reset.
  assign ready     = rst ? 3'b000 : (~occ | gnt);
  assign lsu_ready = ready[SRC_LSU];
  assign mdu_ready = ready[SRC_MDU];
  assign alu_ready = ready[SRC_ALU];

  // Busy reflects held entries only, never the incoming valids.
  assign wb_busy = !rst && (|occ);

  rr_arb3 u_arb (
    .req      (occ),
    .ptr      (ptr),
    .gnt      (gnt),
    .next_ptr (next_ptr)
  );

  // Select the granted slot's destination and data for the output register.
  always_comb begin
    win_rd   = '0;
    win_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt[i]) begin
        win_rd   = slot_rd[i];
        win_data = slot_data[i];
      end
    end
  end

  // Slot storage: a handshake fills a slot (taking priority over the drain
  // of the same slot); a grant without refill empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= 3'b000;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (in_valid[i] && ready[i]) begin
          occ[i]       <= 1'b1;
          slot_rd[i]   <= in_rd[i];
          slot_data[i] <= in_data[i];
        end else if (gnt[i]) begin
          occ[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer and the registered regfile write; x0 targets are
  // consumed without raising the write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= SRC_LSU;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      ptr    <= next_ptr;
      rf_wen <= (|gnt) && (win_rd != '0);
      if (|gnt) begin
        rf_waddr <= win_rd;
        rf_wdata <= win_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a scoreboard queue holds the expected
// regfile writes in order, and each scenario task checks its own timing.
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid, lsu_valid, mdu_valid;
  logic        alu_ready, lsu_ready, mdu_ready;
  logic [4:0]  alu_rd, lsu_rd, mdu_rd;
  logic [63:0] alu_data, lsu_data, mdu_data;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        wb_busy;

  typedef struct packed {
    logic [4:0]  a;
    logic [63:0] d;
  } wr_t;

  wr_t sb[$];
  wr_t mon_exp;
  int  checks = 0;
  int  errors = 0;
  logic prev_wen = 1'b0;
  int  run_len = 0;
  int  max_run = 0;

  wb_arbiter #(.DATA_W(64), .ADDR_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .mdu_valid (mdu_valid),
    .mdu_ready (mdu_ready),
    .mdu_rd    (mdu_rd),
    .mdu_data  (mdu_data),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .wb_busy   (wb_busy)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every write must match the oldest expected entry;
  // also tracks the length of consecutive write runs.
  always @(negedge clk) begin
    if (rf_wen === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_unexpected_write got addr=%0d data=%h required no write", rf_waddr, rf_wdata);
      end else begin
        mon_exp = sb.pop_front();
        if ({rf_waddr, rf_wdata} !== {mon_exp.a, mon_exp.d}) begin
          errors++;
          $display("[TB] FAIL sb_write got addr=%0d data=%h required addr=%0d data=%h", rf_waddr, rf_wdata, mon_exp.a, mon_exp.d);
        end
      end
      run_len = prev_wen ? run_len + 1 : 1;
      if (run_len > max_run) max_run = run_len;
    end
    prev_wen = (rf_wen === 1'b1);
  end

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idle_inputs();
    alu_valid = 1'b0; lsu_valid = 1'b0; mdu_valid = 1'b0;
    alu_rd = '0; lsu_rd = '0; mdu_rd = '0;
    alu_data = '0; lsu_data = '0; mdu_data = '0;
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 50 && sb.size() != 0; c++) begin
      @(negedge clk); #1;
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drain got %0d pending required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({rf_wen, rf_waddr, rf_wdata} !== {1'b0, 5'd0, 64'd0}) begin
        errors++;
        $display("[TB] FAIL reset_outputs got wen=%b addr=%0d data=%h required 0", rf_wen, rf_waddr, rf_wdata);
      end
      checks++;
      if ({lsu_ready, mdu_ready, alu_ready, wb_busy} !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL reset_ready got %b required 0000", {lsu_ready, mdu_ready, alu_ready, wb_busy});
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({lsu_ready, mdu_ready, alu_ready, wb_busy, rf_wen} !== 5'b11100) begin
      errors++;
      $display("[TB] FAIL post_reset got rdy/busy/wen=%b required 11100", {lsu_ready, mdu_ready, alu_ready, wb_busy, rf_wen});
    end
  endtask

  task automatic test_single_alu();
    @(posedge clk); #1;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
    sb.push_back('{a: 5'd5, d: 64'h1234});
    @(posedge clk); #1;
    alu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rf_wen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_early got wen=%b required 0", rf_wen);
    end
    @(negedge clk);
    checks++;
    if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 64'h1234}) begin
      errors++;
      $display("[TB] FAIL single_write got wen=%b addr=%0d data=%h required 1/5/1234", rf_wen, rf_waddr, rf_wdata);
    end
    @(negedge clk);
    checks++;
    if (rf_wen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_one_cycle got wen=%b required 0", rf_wen);
    end
    wait_drain("single");
  endtask

  task automatic test_three_way();
    logic [2:0] exp_rdy [3];
    exp_rdy[0] = 3'b100; exp_rdy[1] = 3'b110; exp_rdy[2] = 3'b111;
    @(posedge clk); #1;
    lsu_valid = 1'b1; lsu_rd = 5'd1; lsu_data = 64'h11;
    mdu_valid = 1'b1; mdu_rd = 5'd2; mdu_data = 64'h22;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h33;
    sb.push_back('{a: 5'd1, d: 64'h11});
    sb.push_back('{a: 5'd2, d: 64'h22});
    sb.push_back('{a: 5'd3, d: 64'h33});
    @(posedge clk); #1;
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({lsu_ready, mdu_ready, alu_ready} !== exp_rdy[c]) begin
        errors++;
        $display("[TB] FAIL three_ready_c%0d got %b required %b", c, {lsu_ready, mdu_ready, alu_ready}, exp_rdy[c]);
      end
    end
    wait_drain("three");
    // Pointer should be back at LSU: MDU must then beat ALU.
    @(posedge clk); #1;
    mdu_valid = 1'b1; mdu_rd = 5'd4; mdu_data = 64'h44;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h55;
    sb.push_back('{a: 5'd4, d: 64'h44});
    sb.push_back('{a: 5'd5, d: 64'h55});
    @(posedge clk); #1;
    idle_inputs();
    wait_drain("three_ptr");
  endtask

  task automatic test_back_to_back();
    max_run = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      alu_valid = 1'b1;
      alu_rd    = 5'(8 + i);
      alu_data  = 64'hA000 + 64'(i);
      sb.push_back('{a: 5'(8 + i), d: 64'hA000 + 64'(i)});
      @(negedge clk);
      checks++;
      if (alu_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stream_ready_%0d got %b required 1", i, alu_ready);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    wait_drain("stream");
    checks++;
    if (max_run != 8) begin
      errors++;
      $display("[TB] FAIL stream_run got %0d required 8", max_run);
    end
  endtask

  task automatic test_x0();
    @(posedge clk); #1;
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 64'hDEAD;
    @(posedge clk); #1;
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (rf_wen !== 1'b0) begin
        errors++;
        $display("[TB] FAIL x0_wen_c%0d got %b required 0", c, rf_wen);
      end
      if (c == 1) begin
        checks++;
        if ({lsu_ready, wb_busy} !== 2'b10) begin
          errors++;
          $display("[TB] FAIL x0_freed got ready/busy=%b required 10", {lsu_ready, wb_busy});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    // Move the pointer off LSU first.
    @(posedge clk); #1;
    lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 64'h66;
    sb.push_back('{a: 5'd6, d: 64'h66});
    @(posedge clk); #1;
    idle_inputs();
    wait_drain("mid_pre");
    // Fill LSU and MDU, then reset before either drains.
    @(posedge clk); #1;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 64'h77;
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 64'h99;
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({lsu_ready, mdu_ready, alu_ready, wb_busy} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL mid_in_reset got %b required 0000", {lsu_ready, mdu_ready, alu_ready, wb_busy});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({rf_wen, wb_busy} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL mid_after_reset got wen/busy=%b required 00", {rf_wen, wb_busy});
    end
    // Pointer reset to LSU: LSU must beat ALU.
    @(posedge clk); #1;
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 64'hAA;
    lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 64'hBB;
    sb.push_back('{a: 5'd11, d: 64'hBB});
    sb.push_back('{a: 5'd10, d: 64'hAA});
    @(posedge clk); #1;
    idle_inputs();
    wait_drain("mid_ptr");
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    $display("[TB] starting wb_arbiter bench");
    test_reset();
    test_single_alu();
    test_three_way();
    test_back_to_back();
    test_x0();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
